// File: rtl/sram_tdp.sv
// True dual-port synchronous RAM with configurable read-during-write behaviour,
// optional output register stage and a post-reset zero-fill sequencer.
module sram_tdp #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 34,
    parameter int DEPTH          = 8,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b,
    output logic                  busy,
    output logic                  collision
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cnt, cnt_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept_a, accept_b;
    logic                  in_a, in_b;
    logic [IDX_W-1:0]      idx_a, idx_b;
    logic                  wr_a, wr_b;
    logic                  coll;
    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

    logic                  p_v_a, p_v_b;
    logic [DATA_WIDTH-1:0] p_q_a, p_q_b;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter parks on the last word instead of wrapping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: ;
            CLEAR: begin
                if (cnt == LAST) state_next = IDLE;
                else             cnt_next   = cnt + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CLEAR);

    // ---------------- request decode ----------------
    assign accept_a = en_a & ~busy & ~rst;
    assign accept_b = en_b & ~busy & ~rst;
    assign in_a     = ({1'b0, addr_a} < DEPTH_W);
    assign in_b     = ({1'b0, addr_b} < DEPTH_W);
    assign idx_a    = addr_a[IDX_W-1:0];
    assign idx_b    = addr_b[IDX_W-1:0];

    // Port A wins a same-address write/write; B's write is suppressed.
    assign coll = accept_a & we_a & accept_b & we_b & (addr_a == addr_b);
    assign wr_a = accept_a & we_a & in_a;
    assign wr_b = accept_b & we_b & in_b & ~(wr_a & (addr_a == addr_b));

    // Array reads see the pre-edge contents, which gives old data cross-port.
    always_comb begin
        rdata_a = '0;
        if (in_a) begin
            if (we_a && RDW_MODE == 0) rdata_a = data_a;
            else                       rdata_a = mem[idx_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (in_b) begin
            if (we_b && RDW_MODE == 0) rdata_b = data_b;
            else                       rdata_b = mem[idx_b];
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt[IDX_W-1:0]] <= '0;
        end else begin
            if (wr_a) mem[idx_a] <= data_a;
            if (wr_b) mem[idx_b] <= data_b;
        end
    end

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            p_v_a     <= 1'b0;
            p_v_b     <= 1'b0;
            p_q_a     <= '0;
            p_q_b     <= '0;
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            q_a       <= '0;
            q_b       <= '0;
            collision <= 1'b0;
        end else begin
            collision <= coll;
            p_v_a     <= accept_a;
            p_v_b     <= accept_b;
            if (accept_a) p_q_a <= rdata_a;
            if (accept_b) p_q_b <= rdata_b;
            if (OUT_REG != 0) begin
                valid_a <= p_v_a;
                valid_b <= p_v_b;
                if (p_v_a) q_a <= p_q_a;
                if (p_v_b) q_b <= p_q_b;
            end else begin
                valid_a <= accept_a;
                valid_b <= accept_b;
                if (accept_a) q_a <= rdata_a;
                if (accept_b) q_b <= rdata_b;
            end
        end
    end

endmodule

// File: tb/tb_sram_tdp.sv
// Directed bench: one default instance (write-first, 1-cycle) and one
// read-first instance with the output register, sharing the same stimulus.
module tb_sram_tdp;

    localparam int AW = 8;
    localparam int DW = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;

    logic [DW-1:0] q_a1, q_b1, q_a2, q_b2;
    logic          valid_a1, valid_b1, busy1, coll1;
    logic          valid_a2, valid_b2, busy2, coll2;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    sram_tdp dut1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a1), .valid_a(valid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b1), .valid_b(valid_b1),
        .busy(busy1), .collision(coll1)
    );

    sram_tdp #(.RDW_MODE(1), .OUT_REG(1)) dut2 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a2), .valid_a(valid_a2),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b2), .valid_b(valid_b2),
        .busy(busy2), .collision(coll2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        en_a = 1'b1; we_a = we; addr_a = addr; data_a = data;
    endtask

    task automatic op_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        en_b = 1'b1; we_b = we; addr_b = addr; data_b = data;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;

        // Request during reset must be ignored.
        op_a(1'b1, 8'd2, 34'h1234);
        tick();
        chk("rst_q_a", q_a1, 0);
        chk("rst_valid_a", valid_a1, 0);
        chk("rst_collision", coll1, 0);
        chk("rst_busy", busy1, 1);

        // Clear sequence: write to 0 while busy must be dropped.
        rst = 1'b0;
        op_a(1'b1, 8'd0, 34'h3FF);
        n = 0;
        while (busy1 && n < 20) begin
            chk("busy_no_valid", valid_a1, 0);
            n++;
            tick();
        end
        idle();
        chk("busy_len", n, 8);
        chk("busy_len_dut2", busy2, 0);

        // Every word reads back zero, one cycle later.
        for (int i = 0; i < 8; i++) begin
            op_a(1'b0, AW'(i), '0);
            tick();
            chk("clr_read_valid", valid_a1, 1);
            chk("clr_read_q", q_a1, 0);
        end
        idle();
        tick();
        chk("read_valid_drop", valid_a1, 0);
        chk("dut2_last_valid", valid_a2, 1);
        tick();
        chk("dut2_valid_drop", valid_a2, 0);

        // Write then read on the other port; dut2 sees it one cycle later.
        op_a(1'b1, 8'd5, 34'h3_0000_0001);
        tick();
        chk("wf_q_a", q_a1, 34'h3_0000_0001);
        chk("wf_valid_a", valid_a1, 1);
        idle();
        op_b(1'b0, 8'd5, '0);
        tick();
        chk("xread_valid_b", valid_b1, 1);
        chk("xread_q_b", q_b1, 34'h3_0000_0001);
        chk("dut2_rf_valid_a", valid_a2, 1);
        chk("dut2_rf_q_a", q_a2, 0);
        chk("dut2_early_valid_b", valid_b2, 0);
        idle();
        tick();
        chk("q_b_hold", q_b1, 34'h3_0000_0001);
        chk("valid_b_drop", valid_b1, 0);
        chk("dut2_valid_b", valid_b2, 1);
        chk("dut2_q_b", q_b2, 34'h3_0000_0001);

        // Same-address write/write: A wins, collision pulses once.
        op_a(1'b1, 8'd3, 34'h1);
        op_b(1'b1, 8'd3, 34'h2);
        tick();
        chk("collision_hi", coll1, 1);
        idle();
        tick();
        chk("collision_lo", coll1, 0);
        chk("dut2_collision_lo", coll2, 0);
        op_a(1'b0, 8'd3, '0);
        tick();
        chk("coll_winner", q_a1, 34'h1);
        idle();

        // Cross-port read-during-write returns the old word.
        op_a(1'b1, 8'd3, 34'hA);
        tick();
        idle();
        tick();
        op_a(1'b1, 8'd3, 34'hB);
        op_b(1'b0, 8'd3, '0);
        tick();
        chk("rdw_q_b", q_b1, 34'hA);
        chk("rdw_q_a_wf", q_a1, 34'hB);
        idle();
        tick();
        chk("dut2_rdw_q_b", q_b2, 34'hA);
        chk("dut2_rdw_q_a_rf", q_a2, 34'hA);
        chk("q_a_hold", q_a1, 34'hB);
        chk("valid_a_idle", valid_a1, 0);

        // Out-of-range write ignored; out-of-range read is zero with valid.
        op_a(1'b1, 8'd9, 34'h55);
        tick();
        chk("oor_wr_valid", valid_a1, 1);
        chk("oor_wr_q", q_a1, 0);
        idle();
        tick();
        chk("dut2_oor_valid", valid_a2, 1);
        chk("dut2_oor_q", q_a2, 0);
        op_b(1'b0, 8'd1, '0);
        tick();
        chk("oor_no_alias", q_b1, 0);
        op_b(1'b0, 8'd9, '0);
        tick();
        chk("oor_rd_valid", valid_b1, 1);
        chk("oor_rd_q", q_b1, 0);
        idle();
        tick();

        // Reset part-way through a clear restarts it from word 0.
        rst = 1'b1;
        tick();
        chk("rst2_q_a", q_a1, 0);
        chk("rst2_valid_b", valid_b1, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_clear_busy", busy1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy1 && n < 20) begin
            n++;
            tick();
        end
        chk("reclear_busy_len", n, 8);
        op_a(1'b0, 8'd5, '0);
        tick();
        chk("reclear_word5", q_a1, 0);
        chk("reclear_valid", valid_a1, 1);
        op_a(1'b0, 8'd3, '0);
        tick();
        chk("reclear_word3", q_a1, 0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_tdp.md
SRAM_TDP -- requirements
Module: sram_tdp

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: address width of both ports.
REQ-002 Parameter DATA_WIDTH, default 34: word width of both ports.
REQ-003 Parameter DEPTH, default 8: number of words; DEPTH SHALL be at most 2**ADDR_WIDTH.
REQ-004 Parameter RDW_MODE, default 0: same-port read-during-write, 0 = write-first (new data), 1 = read-first (old data).
REQ-005 Parameter OUT_REG, default 0: 1 adds one output register stage on both ports.
REQ-006 Parameter CLEAR_ON_RESET, default 1: 1 zero-fills the array after reset.
REQ-007 Ports (name  direction  width  meaning):
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en_a  in  1  port A request.
- we_a  in  1  port A write (qualified by en_a).
- addr_a  in  ADDR_WIDTH  port A address.
- data_a  in  DATA_WIDTH  port A write data.
- q_a  out  DATA_WIDTH  port A read data.
- valid_a  out  1  q_a holds the response to an accepted port A request.
- en_b, we_b, addr_b, data_b, q_b, valid_b: port B equivalents, same widths.
- busy  out  1  clear in progress; requests ignored.
- collision  out  1  one-cycle flag for a same-address write/write conflict.

Function
REQ-008 A request is accepted when en_x=1 and busy=0; requests while busy=1 SHALL be dropped, with no write and no valid.
REQ-009 Read latency SHALL be 1 cycle from acceptance to valid_x=1 when OUT_REG=0, and 2 cycles when OUT_REG=1; one valid pulse per accepted request, fully pipelined (one request per cycle per port).
REQ-010 An accepted write SHALL update the array at the clock edge and SHALL also produce a valid_x response whose q_x is data_x (RDW_MODE=0) or the prior word (RDW_MODE=1).
REQ-011 Cross-port read-during-write (A reads address X while B writes X, or vice versa) SHALL return the old word.
REQ-012 Both ports writing the same address in one accepted cycle: port A's data SHALL be stored, and collision SHALL pulse high on the next cycle.
REQ-013 Address >= DEPTH: the write SHALL be ignored, the read SHALL return all zeros, and valid SHALL still be asserted.
REQ-014 q_x SHALL hold its last value while valid_x=0.
REQ-015 Clear FSM states: IDLE, CLEAR. On rst with CLEAR_ON_RESET=1 the next state SHALL be CLEAR with the counter at 0; each CLEAR cycle writes 0 to word[counter] and increments the counter; after writing word DEPTH-1 the FSM goes to IDLE.
REQ-016 busy SHALL equal 1 exactly while the state is CLEAR, i.e. for DEPTH cycles following the reset cycle.
REQ-017 With CLEAR_ON_RESET=0 the FSM SHALL stay in IDLE, busy SHALL stay 0, and array contents are undefined after power-up and preserved across rst.
REQ-018 The counter width SHALL be ADDR_WIDTH; there SHALL be no wrap-around past DEPTH-1.

Reset
REQ-019 While rst=1: q_a=q_b=0, valid_a=valid_b=0, collision=0, pipeline stages flushed, counter=0.
REQ-020 Assertion of rst mid-CLEAR SHALL restart the clear from word 0.
REQ-021 Requests presented in the cycle rst=1 SHALL be ignored.

Verification
REQ-022 Default parameters, rst for 1 cycle -> busy=1 for 8 cycles; then a read of every address returns 0, with valid 1 cycle later.
REQ-023 A writes 0x3_0000_0001 to address 5; next cycle B reads 5 -> valid_b=1 with q_b=0x3_0000_0001 one cycle later; with OUT_REG=1 the response arrives two cycles later.
REQ-024 A and B write 0x1 and 0x2 to address 3 in the same cycle -> collision=1 on the next cycle; a later read of 3 returns 0x1.
REQ-025 Address 3 holds 0xA; A writes 0xB to 3 while B reads 3 -> q_b=0xA; q_a=0xB (RDW_MODE=0) or 0xA (RDW_MODE=1).
REQ-026 Write to address 9 with DEPTH=8 -> array unchanged, read of 9 returns 0 with valid; rst at clear cycle 4 -> busy lasts 8 further cycles.
